// File: rtl/uart_tx_feeder_pkg.sv
// Shared UART definitions: byte width, default bit period and the feeder FSM
// state encodings. Used by the feeder top, its FIFO and its bus interface.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_BIT_CLK_DEFAULT = 87;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Plain 3-bit constants so older blocks that compare raw state codes still work
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  // Width of a down-counter that must hold the value 'cycles'; never below 1 bit
  function automatic int gap_cnt_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Bus bundle between the host/transmitter side and the transmit feeder.
// tx_overflow exists only when UART_TX_FEEDER_OVF_EN is defined.
interface uart_tx_feeder_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  uart_byte_t       host_wdata;
  logic             host_wr;
  logic             host_full;
  logic [CNT_W-1:0] host_count;
  logic             cts;
  logic             tx_ready;
  logic             tx_load;
  uart_byte_t       txdata;
`ifdef UART_TX_FEEDER_OVF_EN
  logic             tx_overflow;
`endif

  modport master (
    output host_wdata, host_wr, cts, tx_ready,
    input  host_full, host_count, tx_load, txdata
`ifdef UART_TX_FEEDER_OVF_EN
    , input tx_overflow
`endif
  );

  modport slave (
    input  host_wdata, host_wr, cts, tx_ready,
    output host_full, host_count, tx_load, txdata
`ifdef UART_TX_FEEDER_OVF_EN
    , output tx_overflow
`endif
  );

endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// uart_sync_fifo: DEPTH x WIDTH synchronous FIFO with wrap-bit pointers.
// Writes while full and reads while empty are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rptr[AW-1:0]];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= wr_data;
  end

  // Pointer update; reset empties the FIFO by aligning both pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: host byte FIFO feeding a UART transmitter one byte at a time,
// honouring cts and inserting GAP_BITS idle bit-times after each byte.
// Optional feature macro: UART_TX_FEEDER_OVF_EN adds the sticky tx_overflow flag.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BIT_CLK  = UART_BIT_CLK_DEFAULT,
  parameter int GAP_BITS = 1
) (
  input logic             clk,
  input logic             reset,
  uart_tx_feeder_if.slave bus
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int GAP_CYC = GAP_BITS * BIT_CLK;
  localparam int GAP_W   = gap_cnt_width(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [GAP_W-1:0] gap_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  uart_byte_t       fifo_head;
  logic             pop;
  logic             start_load;
  logic             tx_load_q;
  uart_byte_t       txdata_q;

  assign pop        = (state == LOAD);
  assign start_load = (state == IDLE) && (state_nx == LOAD);

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.host_wr),
    .wr_data (bus.host_wdata),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.host_full  = fifo_full;
  assign bus.host_count = fifo_count;
  assign bus.tx_load    = tx_load_q;
  assign bus.txdata     = txdata_q;

  // Next-state logic; cts only gates the start of a byte, never one in flight
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!fifo_empty && bus.cts && bus.tx_ready) state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    if (!bus.tx_ready) state_nx = DRAIN;
      DRAIN:   if (bus.tx_ready) state_nx = (GAP_CYC == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt <= GAP_ONE) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, registered load strobe/data and the idle-gap down-counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_load_q <= 1'b0;
      txdata_q  <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nx;
      tx_load_q <= start_load;
      if (start_load) txdata_q <= fifo_head;
      if (state == DRAIN && state_nx == GAP) gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_q;

  // Sticky flag for any write dropped because the FIFO was full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else if (bus.host_wr && fifo_full) ovf_q <= 1'b1;
  end

  assign bus.tx_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: scoreboard of accepted bytes checked against
// each tx_load, plus a simple transmitter model that drives tx_ready.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH    = 16;
  localparam int BIT_CLK  = 87;
  localparam int GAP_BITS = 1;
  localparam int GAP_CYC  = GAP_BITS * BIT_CLK;
  localparam int TX_BUSY  = 20;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   cycleNo;
  int   loadCount;
  int   riseCycle;
  int   sinceLoad;
  bit   checkGap;
  int   base;
  uart_byte_t expQ[$];

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus();

  uart_tx_feeder #(
    .DEPTH    (DEPTH),
    .BIT_CLK  (BIT_CLK),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time the inter-byte gap
  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Track how long tx_ready stays high after a load
  always @(posedge clk) begin
    if (!reset) sinceLoad <= -1;
    else if (bus.tx_load) sinceLoad <= 0;
    else if (sinceLoad >= 0 && !bus.tx_ready) sinceLoad <= -1;
    else if (sinceLoad >= 0) sinceLoad <= sinceLoad + 1;
  end

  // The transmitter must have started within one bit time of a load
  always @(negedge clk) begin
    assert (sinceLoad <= BIT_CLK)
      else $error("[TB] FAIL tx_ready_drop: %0d cycles, limit %0d", sinceLoad, BIT_CLK);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input uart_byte_t data, input bit accept);
    bus.host_wdata = data;
    bus.host_wr    = 1'b1;
    if (accept) expQ.push_back(data);
    tick();
    bus.host_wr    = 1'b0;
  endtask

  task automatic waitLoads(input string tag, input int target, input int bound);
    for (int i = 0; i < bound && loadCount < target; i++) tick();
    checkOutput(tag, loadCount, target);
  endtask

  task automatic waitReady(input string tag, input logic level, input int bound);
    for (int i = 0; i < bound && bus.tx_ready !== level; i++) tick();
    checkOutput(tag, bus.tx_ready, level);
  endtask

  // Transmitter model: capture on tx_load, go busy, then return to ready
  initial begin
    uart_byte_t exp;
    bus.tx_ready = 1'b1;
    loadCount = 0;
    riseCycle = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset && bus.tx_load) begin
        loadCount++;
        if (checkGap && riseCycle > 0) begin
          checkOutput("gap_min", (cycleNo - riseCycle > GAP_CYC) ? 1 : 0, 1);
          checkOutput("gap_max", (cycleNo - riseCycle <= GAP_CYC + 6) ? 1 : 0, 1);
        end
        if (expQ.size() == 0) begin
          checkOutput("load_unexpected", 1, 0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("txdata", bus.txdata, exp);
        end
        @(posedge clk);
        #1;
        checkOutput("load_pulse", bus.tx_load, 0);
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
        repeat (TX_BUSY) begin
          @(posedge clk);
          #1;
        end
        bus.tx_ready = 1'b1;
        riseCycle = cycleNo;
      end
    end
  end

  // Hard time limit so the bench always ends
  initial begin
    #600000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    cycleNo     = 0;
    checkGap    = 1'b0;
    reset       = 1'b0;
    bus.host_wr    = 1'b0;
    bus.host_wdata = '0;
    bus.cts        = 1'b1;

    repeat (3) tick();
    checkOutput("rst_full", bus.host_full, 0);
    checkOutput("rst_count", bus.host_count, 0);
    checkOutput("rst_load", bus.tx_load, 0);
    checkOutput("rst_txdata", bus.txdata, 0);
`ifdef UART_TX_FEEDER_OVF_EN
    checkOutput("rst_ovf", bus.tx_overflow, 0);
`endif
    reset = 1'b1;
    repeat (2) tick();

    // Single byte: load two cycles after the write
    applyStimulus(8'hA5, 1'b1);
    checkOutput("a5_count1", bus.host_count, 1);
    tick();
    checkOutput("a5_load", bus.tx_load, 1);
    checkOutput("a5_txdata", bus.txdata, 8'hA5);
    tick();
    checkOutput("a5_count0", bus.host_count, 0);
    repeat (200) tick();

    // Fill with cts low, overflow by one, then drain in order
    bus.cts = 1'b0;
    base = loadCount;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(8'(i), 1'b1);
      if (i == DEPTH - 2) begin
        checkOutput("fill_notfull", bus.host_full, 0);
        checkOutput("fill_count15", bus.host_count, DEPTH - 1);
      end
    end
    checkOutput("fill_full", bus.host_full, 1);
    checkOutput("fill_count16", bus.host_count, DEPTH);
    applyStimulus(8'hEE, 1'b0);
    checkOutput("drop_count", bus.host_count, DEPTH);
    checkOutput("drop_full", bus.host_full, 1);
`ifdef UART_TX_FEEDER_OVF_EN
    checkOutput("ovf_set", bus.tx_overflow, 1);
`endif
    repeat (20) tick();
    checkOutput("cts_hold", loadCount, base);
    riseCycle = 0;
    checkGap  = 1'b1;
    bus.cts   = 1'b1;
    waitLoads("burst_loads", base + DEPTH, 3000);
    checkGap  = 1'b0;
    repeat (200) tick();
    checkOutput("burst_empty", expQ.size(), 0);
    checkOutput("burst_count", bus.host_count, 0);
`ifdef UART_TX_FEEDER_OVF_EN
    checkOutput("ovf_sticky", bus.tx_overflow, 1);
`endif

    // Drop cts while a byte is draining: it completes, the next one waits
    base = loadCount;
    applyStimulus(8'h51, 1'b1);
    applyStimulus(8'h52, 1'b1);
    waitReady("drain_busy", 1'b0, 50);
    bus.cts = 1'b0;
    waitReady("drain_done", 1'b1, 100);
    repeat (200) tick();
    checkOutput("cts_block_loads", loadCount, base + 1);
    checkOutput("cts_block_count", bus.host_count, 1);
    bus.cts = 1'b1;
    waitLoads("cts_resume", base + 2, 50);
    repeat (200) tick();

    // Reset during the gap with three bytes still queued
    base = loadCount;
    for (int i = 0; i < 4; i++) applyStimulus(8'h31 + 8'(i), 1'b1);
    waitLoads("gap_first", base + 1, 20);
    waitReady("gap_busy", 1'b0, 50);
    waitReady("gap_ready", 1'b1, 100);
    repeat (10) tick();
    checkOutput("gap_queued", bus.host_count, 3);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_count", bus.host_count, 0);
    checkOutput("mid_rst_full", bus.host_full, 0);
    checkOutput("mid_rst_load", bus.tx_load, 0);
    checkOutput("mid_rst_txdata", bus.txdata, 0);
`ifdef UART_TX_FEEDER_OVF_EN
    checkOutput("mid_rst_ovf", bus.tx_overflow, 0);
`endif
    expQ.delete();
    repeat (3) tick();
    reset = 1'b1;
    repeat (300) tick();
    checkOutput("post_rst_loads", loadCount, base + 1);
    checkOutput("post_rst_count", bus.host_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
